// File: rtl/sigmoid_scheduler_pkg.sv
// Shared types and constants for the sigmoid scheduler and its benches.
// Fixed-point format is Q6.11 (signed, 18 bits) unless overridden at the top.
package sigmoid_scheduler_pkg;

  localparam int unsigned QINT_BITS  = 6;
  localparam int unsigned QFRAC_BITS = 11;
  localparam int unsigned Q_BW       = QINT_BITS + QFRAC_BITS + 1;

  localparam logic signed [Q_BW-1:0] Q_ONE  = 18'sd2048;
  localparam logic signed [Q_BW-1:0] Q_HALF = 18'sd1024;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StRun    = 2'd2,
    StDone   = 2'd3
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sigmoid_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above pointer, with wrap.
// Kept generic so other shared activation units can reuse it.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] pointer,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            any_req
);

  logic            found;
  int unsigned     j;
  logic [IdxW-1:0] jw;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    j       = 0;
    jw      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j  = (32'(pointer) + k) % N;
      jw = IdxW'(j);
      if (!found && req[jw]) begin
        found   = 1'b1;
        gnt[jw] = 1'b1;
        idx     = jw;
      end
    end
  end

endmodule

// File: rtl/sigmoid_scheduler.sv
// Shares one multi-cycle sigmoid unit between N_REQ requesters, round-robin.
// The unit's phase is realigned by pulsing sig_rst for one cycle per operation.
module sigmoid_scheduler
  import sigmoid_scheduler_pkg::*;
#(
  parameter int unsigned QN          = 6,
  parameter int unsigned QM          = 11,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SIG_LATENCY = 6,
  localparam int unsigned BW         = QN + QM + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*BW-1:0]    req_operand,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic signed [BW-1:0]   rsp_data,
  output logic                   busy,
  output logic                   sig_rst,
  output logic signed [BW-1:0]   sig_operand,
  input  logic signed [BW-1:0]   sig_result
);

  localparam int unsigned IdxW = idx_width(N_REQ);
  localparam int unsigned CntW = idx_width(SIG_LATENCY);
  localparam logic [CntW-1:0] CntLast = CntW'(SIG_LATENCY - 1);

  state_e                state_q;
  logic [IdxW-1:0]       ptr_q;
  logic [IdxW-1:0]       gnt_q;
  logic [CntW-1:0]       cnt_q;
  logic signed [BW-1:0]  op_q;

  logic [N_REQ-1:0]      gnt_oh;
  logic [IdxW-1:0]       gnt_idx;
  logic                  any_req;

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_arb (
    .req     (req_valid),
    .pointer (ptr_q),
    .gnt     (gnt_oh),
    .idx     (gnt_idx),
    .any_req (any_req)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            op_q    <= req_operand[32'(gnt_idx)*BW +: BW];
            gnt_q   <= gnt_idx;
            ptr_q   <= (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
            state_q <= StLaunch;
          end
        end
        StLaunch: begin
          cnt_q   <= '0;
          state_q <= StRun;
        end
        StRun: begin
          cnt_q <= cnt_q + 1'b1;
          // Sample at the fixed phase; rsp_valid is registered so it lines up with DONE.
          if (cnt_q == CntLast) begin
            rsp_data  <= sig_result;
            rsp_valid <= N_REQ'(1) << gnt_q;
            state_q   <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle && !reset) ? gnt_oh : '0;
  assign busy        = (state_q != StIdle);
  assign sig_rst     = reset | (state_q == StLaunch);
  assign sig_operand = op_q;

endmodule

// File: tb/tb_sigmoid_scheduler.sv
// Scoreboard bench for sigmoid_scheduler with a behavioural phase-locked sigmoid unit.
module tb_sigmoid_scheduler;
  import sigmoid_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int BW  = Q_BW;
  localparam int LAT = 6;

  logic                 clock;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N*BW-1:0]      req_operand;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         rsp_valid;
  logic signed [BW-1:0] rsp_data;
  logic                 busy;
  logic                 sig_rst;
  logic signed [BW-1:0] sig_operand;
  logic signed [BW-1:0] sig_result;

  logic                 lane_vld [N];
  logic signed [BW-1:0] lane_op  [N];

  sigmoid_scheduler #(
    .QN          (QINT_BITS),
    .QM          (QFRAC_BITS),
    .N_REQ       (N),
    .SIG_LATENCY (LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_operand (req_operand),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .sig_rst     (sig_rst),
    .sig_operand (sig_operand),
    .sig_result  (sig_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    req_valid   = '0;
    req_operand = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = lane_vld[i];
      req_operand[i*BW +: BW]  = lane_op[i];
    end
  end

  // Reference activation: clamp(1020 + x/4, 0, ONE); sigmoid(0) = 0x3FC.
  function automatic logic signed [BW-1:0] sig_model(input logic signed [BW-1:0] x);
    int v;
    v = 1020 + (int'(x) >>> 2);
    if (v < 0) v = 0;
    if (v > int'(Q_ONE)) v = int'(Q_ONE);
    return BW'(v);
  endfunction

  // Behavioural sigmoid unit: output is only valid in a narrow phase window after reset.
  logic [2:0] phase;
  always @(posedge clock) begin
    if (sig_rst) phase <= '0;
    else         phase <= phase + 3'd1;
  end
  assign sig_result = (phase >= 3'(LAT - 1) && phase <= 3'(LAT)) ? sig_model(sig_operand)
                                                                  : 18'sh2AAAA;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int                   lane;
    logic signed [BW-1:0] data;
    int                   due;
  } exp_t;

  exp_t                 sb[$];
  int                   acc_q[$];
  int                   acc_t[$];
  int                   cyc = 0;
  logic signed [BW-1:0] last_data = '0;

  // Monitor: push expectations on accept, pop and compare on each response pulse.
  always @(negedge clock) begin
    exp_t e;
    logic [N-1:0] acc;
    cyc++;
    if (reset) begin
      sb.delete();
    end else begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_lane", 32'(rsp_valid), 32'(N'(1) << e.lane));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_latency", cyc, e.due);
          last_data = rsp_data;
        end
      end
      acc = req_valid & req_ready;
      if (acc != '0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            e.lane = i;
            e.data = sig_model(req_operand[i*BW +: BW]);
            e.due  = cyc + LAT + 2;
            sb.push_back(e);
            acc_q.push_back(i);
            acc_t.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic send(input int lane, input logic signed [BW-1:0] op, output int waited);
    waited        = 0;
    lane_op[lane]  = op;
    lane_vld[lane] = 1'b1;
    forever begin
      @(negedge clock);
      if (req_ready[lane]) break;
      waited++;
      if (waited > 300) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clock);
    #1;
    lane_vld[lane] = 1'b0;
    lane_op[lane]  = BW'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("drain", sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  int w[N];
  int base;
  int exp_ord[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      lane_vld[i] = 1'b0;
      lane_op[i]  = '0;
    end
    lane_vld[0] = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_sig_operand", 32'(sig_operand), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sig_rst", 32'(sig_rst), 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    lane_vld[0] = 1'b0;

    // Single request, lane 0, operand 0.
    send(0, 18'sd0, w[0]);
    check("t1_accept_wait", w[0], 0);
    drain();
    check("t1_data", 32'(last_data), 32'h3FC);

    // Saturation at both ends.
    send(2, 18'sd12288, w[2]);
    drain();
    check("t2_pos_sat", 32'(last_data), 32'(Q_ONE));
    send(1, -18'sd12288, w[1]);
    drain();
    check("t2_neg_sat", 32'(last_data), 32'd0);

    // All lanes contending from reset.
    do_reset();
    base = acc_q.size();
    fork
      begin send(0, 18'sd1000, w[0]); send(0, -18'sd3000, w[0]); end
      begin send(1, 18'sd4000, w[1]); send(1, 18'sd500, w[1]); end
      begin send(2, -18'sd800, w[2]); end
      begin send(3, 18'sd7000, w[3]); end
    join
    drain();
    check("t3_count", acc_q.size() - base, 6);
    for (int i = 0; i < 6 && base + i < acc_q.size(); i++) begin
      check("t3_order", acc_q[base+i], exp_ord[i]);
      if (i > 0) check("t3_period", acc_t[base+i] - acc_t[base+i-1], LAT + 3);
    end

    // Late arrival on lane 3 while lane 1 is running.
    base = acc_q.size();
    send(1, 18'sd3000, w[1]);
    fork
      begin
        repeat (2) @(posedge clock);
        #1;
        send(3, -18'sd5000, w[3]);
      end
      begin
        repeat (2) @(posedge clock);
        for (int i = 0; i < 6; i++) begin
          @(negedge clock);
          check("t4_ready_busy", 32'(req_ready), 32'd0);
        end
        @(negedge clock);
        check("t4_ready_idle", 32'(req_ready), 32'b1000);
      end
    join
    drain();
    if (acc_q.size() >= base + 2) begin
      check("t4_order", acc_q[base+1], 3);
      check("t4_gap", acc_t[base+1] - acc_t[base], LAT + 3);
    end else begin
      check("t4_accepts", acc_q.size() - base, 2);
    end
    check("t4_data", 32'(last_data), 32'(sig_model(-18'sd5000)));

    // Reset in the middle of RUN (cnt = 3).
    send(0, 18'sd4096, w[0]);
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("t5_sig_rst", 32'(sig_rst), 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rsp_data", 32'(rsp_data), 32'd0);
    check("t5_sig_rst_rel", 32'(sig_rst), 32'd0);
    repeat (10) @(negedge clock);
    @(posedge clock);
    #1;
    send(2, 18'sd2000, w[2]);
    check("t5_accept_wait", w[2], 0);
    drain();
    check("t5_data", 32'(last_data), 32'(sig_model(18'sd2000)));

    // Operand scrambled after accept must not reach the unit.
    send(3, -18'sd2048, w[3]);
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clock);
      check("t6_sig_operand", 32'(sig_operand), 32'(-18'sd2048));
      check("t6_sig_rst", 32'(sig_rst), (i == 0) ? 32'd1 : 32'd0);
    end
    drain();
    check("t6_data", 32'(last_data), 32'(sig_model(-18'sd2048)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
